// File: rtl/branch_ctrl.sv
// branch_ctrl: branch/jump condition evaluation and PC-redirect sequencer.
// Accepts one resolve request at a time; a taken decision drives a held
// redirect to fetch until acknowledged, then a fixed-length pipeline flush.
module branch_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic             branch,
  input  logic             jump,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic [XLEN-1:0]  target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic             br_illegal,
  output logic [CNT_W-1:0] taken_count
);

  // Flush counter must hold FLUSH_CYCLES; keep at least one bit when it is 0.
  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REDIRECT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  logic [1:0]       r_state;
  logic [FC_W-1:0]  r_flush_cnt;
  logic             r_br_ready;
  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_flush;
  logic             r_br_illegal;
  logic [CNT_W-1:0] r_taken_count;

  logic             w_accept;
  logic             w_cond;
  logic             w_taken;
  logic             w_illegal;
  logic [XLEN-1:0]  w_target_aligned;

  assign w_accept         = br_valid & r_br_ready;
  assign w_taken          = jump | (branch & w_cond);
  assign w_illegal        = branch & ~jump & (funct3[2:1] == 2'b01);
  // Instruction targets are halfword aligned; bit 0 is always cleared.
  assign w_target_aligned = target & ~{{(XLEN-1){1'b0}}, 1'b1};

  // Evaluate the B-type condition from the ALU flags.
  always_comb begin
    w_cond = 1'b0;
    case (funct3)
      3'b000:  w_cond = zero;
      3'b001:  w_cond = ~zero;
      3'b100:  w_cond = lt;
      3'b101:  w_cond = ~lt;
      3'b110:  w_cond = ltu;
      3'b111:  w_cond = ~ltu;
      default: w_cond = 1'b0;
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_flush_cnt      <= '0;
      r_br_ready       <= 1'b1;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_br_illegal     <= 1'b0;
      r_taken_count    <= '0;
    end else begin
      r_br_illegal <= w_accept & w_illegal;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_taken) begin
            r_state          <= S_REDIRECT;
            r_redirect_pc    <= w_target_aligned;
            r_taken_count    <= r_taken_count + CNT_W'(1);
            r_br_ready       <= 1'b0;
            r_redirect_valid <= 1'b1;
          end
        end
        S_REDIRECT: begin
          if (redirect_ack) begin
            r_redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              r_state    <= S_IDLE;
              r_br_ready <= 1'b1;
            end else begin
              r_state     <= S_FLUSH;
              r_flush     <= 1'b1;
              r_flush_cnt <= FC_W'(FLUSH_CYCLES);
            end
          end
        end
        S_FLUSH: begin
          // The final flush cycle is the one where the counter reads 1.
          if (r_flush_cnt <= FC_W'(1)) begin
            r_state     <= S_IDLE;
            r_flush     <= 1'b0;
            r_br_ready  <= 1'b1;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt - FC_W'(1);
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_br_ready       <= 1'b1;
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
        end
      endcase
    end
  end

  assign br_ready       = r_br_ready;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign br_illegal     = r_br_illegal;
  assign taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl: default, narrow-counter and
// no-flush instances share data inputs but have private valid/ack.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] target = 32'h0;

  logic        br_valid = 1'b0, redirect_ack = 1'b0;
  logic        br_ready, redirect_valid, flush, br_illegal;
  logic [31:0] redirect_pc;
  logic [15:0] taken_count;

  logic        w_valid = 1'b0, w_ack = 1'b0;
  logic        w_ready, w_rv, w_flush, w_ill;
  logic [31:0] w_pc;
  logic [1:0]  w_count;

  logic        n_valid = 1'b0, n_ack = 1'b0;
  logic        n_ready, n_rv, n_flush, n_ill;
  logic [31:0] n_pc;
  logic [15:0] n_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  branch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .branch(branch), .jump(jump), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .target(target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .flush(flush), .br_illegal(br_illegal),
    .taken_count(taken_count)
  );

  branch_ctrl #(.CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .br_valid(w_valid), .br_ready(w_ready),
    .branch(branch), .jump(jump), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .target(target), .redirect_valid(w_rv), .redirect_pc(w_pc),
    .redirect_ack(w_ack), .flush(w_flush), .br_illegal(w_ill),
    .taken_count(w_count)
  );

  branch_ctrl #(.FLUSH_CYCLES(0)) u_nf (
    .clk(clk), .rst_n(rst_n), .br_valid(n_valid), .br_ready(n_ready),
    .branch(branch), .jump(jump), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .target(target), .redirect_valid(n_rv), .redirect_pc(n_pc),
    .redirect_ack(n_ack), .flush(n_flush), .br_illegal(n_ill),
    .taken_count(n_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written B-type truth table.
  function automatic logic exp_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      3'b111:  return !lu;
      default: return 1'b0;
    endcase
  endfunction

  // One resolve on u_dut; taken ones are acked immediately and flushed.
  task automatic resolve(input logic [2:0] f3, input logic [2:0] flags);
    logic t;
    t = exp_taken(f3, flags[2], flags[1], flags[0]);
    branch = 1'b1; jump = 1'b0; funct3 = f3;
    {zero, lt, ltu} = flags;
    target = 32'h400;
    br_valid = 1'b1;
    tick();
    if (t) begin
      exp_count++;
      br_valid = 1'b0;
      chk($sformatf("sweep_rv f3=%0d fl=%0d", f3, flags), {31'b0, redirect_valid}, 32'd1);
      redirect_ack = 1'b1;
      tick();
      redirect_ack = 1'b0;
      tick();
      tick();
      chk($sformatf("sweep_ready f3=%0d fl=%0d", f3, flags), {31'b0, br_ready}, 32'd1);
    end else begin
      chk($sformatf("sweep_nt f3=%0d fl=%0d", f3, flags),
          {30'b0, br_ready, redirect_valid}, 32'd2);
    end
    chk($sformatf("sweep_cnt f3=%0d fl=%0d", f3, flags), {16'b0, taken_count}, 32'(exp_count));
  endtask

  initial begin
    logic [2:0] codes [6];
    codes = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    // Reset state
    #12;
    chk("rst_ready", {31'b0, br_ready}, 32'd1);
    chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
    chk("rst_cnt", {16'b0, taken_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: BEQ taken, ack next cycle
    branch = 1'b1; funct3 = 3'b000; zero = 1'b1; target = 32'h100; br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    exp_count = 1;
    chk("t1_rv", {31'b0, redirect_valid}, 32'd1);
    chk("t1_pc", redirect_pc, 32'h100);
    chk("t1_ready0", {31'b0, br_ready}, 32'd0);
    chk("t1_cnt", {16'b0, taken_count}, 32'd1);
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    chk("t1_rv_drop", {31'b0, redirect_valid}, 32'd0);
    chk("t1_flush_a", {31'b0, flush}, 32'd1);
    tick();
    chk("t1_flush_b", {30'b0, flush, br_ready}, 32'd2);
    tick();
    chk("t1_flush_end", {30'b0, flush, br_ready}, 32'd1);

    // Ack outside REDIRECT has no effect
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    chk("ack_idle", {29'b0, br_ready, redirect_valid, flush}, 32'd4);

    // 2: full funct3 x flags sweep
    for (int c = 0; c < 6; c++)
      for (int f = 0; f < 8; f++)
        resolve(codes[c], 3'(f));
    br_valid = 1'b0;
    tick();

    // 3: JALR with ack delayed 5 cycles; request held across busy period
    branch = 1'b0; jump = 1'b1; target = 32'h203; br_valid = 1'b1;
    tick();
    exp_count++;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_rv c%0d", i), {31'b0, redirect_valid}, 32'd1);
      chk($sformatf("t3_pc c%0d", i), redirect_pc, 32'h202);
      chk($sformatf("t3_ready c%0d", i), {31'b0, br_ready}, 32'd0);
      if (i == 4) redirect_ack = 1'b1;
      tick();
    end
    redirect_ack = 1'b0;
    chk("t3_flush_a", {30'b0, flush, br_ready}, 32'd2);
    tick();
    chk("t3_flush_b", {30'b0, flush, br_ready}, 32'd2);
    chk("t3_cnt_held", {16'b0, taken_count}, 32'(exp_count));
    tick();
    chk("t3_ready", {30'b0, flush, br_ready}, 32'd1);
    tick();
    exp_count++;
    br_valid = 1'b0;
    chk("t3_reaccept", {31'b0, redirect_valid}, 32'd1);
    chk("t3_cnt", {16'b0, taken_count}, 32'(exp_count));
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    tick();
    tick();

    // 4: illegal funct3
    jump = 1'b0; branch = 1'b1; funct3 = 3'b010; br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    chk("t4_ill", {31'b0, br_illegal}, 32'd1);
    chk("t4_quiet", {29'b0, br_ready, redirect_valid, flush}, 32'd4);
    tick();
    chk("t4_pulse", {31'b0, br_illegal}, 32'd0);
    chk("t4_cnt", {16'b0, taken_count}, 32'(exp_count));

    // 5a: async reset mid-FLUSH
    branch = 1'b0; jump = 1'b1; target = 32'h80; br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    chk("t5_in_flush", {31'b0, flush}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_flags", {28'b0, br_ready, redirect_valid, flush, br_illegal}, 32'd8);
    chk("t5_rst_pc", redirect_pc, 32'h0);
    chk("t5_rst_cnt", {16'b0, taken_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_idle", {29'b0, br_ready, redirect_valid, flush}, 32'd4);

    // 5b: CNT_W=2 wraps after four taken jumps
    for (int i = 0; i < 5; i++) begin
      w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
      chk($sformatf("t5_wcnt j%0d", i), {30'b0, w_count}, 32'((i + 1) % 4));
      w_ack = 1'b1;
      tick();
      w_ack = 1'b0;
      tick();
      tick();
    end
    chk("t5_wrap", {30'b0, w_count}, 32'd1);

    // 6: FLUSH_CYCLES=0
    target = 32'h300; n_valid = 1'b1;
    tick();
    n_valid = 1'b0;
    chk("t6_rv", {31'b0, n_rv}, 32'd1);
    chk("t6_pc", n_pc, 32'h300);
    n_ack = 1'b1;
    tick();
    n_ack = 1'b0;
    chk("t6_idle", {29'b0, n_ready, n_rv, n_flush}, 32'd4);
    tick();
    chk("t6_noflush", {29'b0, n_ready, n_rv, n_flush}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
